// File: rtl/ip_amba_axi_slave_mem.sv
// AXI4 memory-mapped slave: independent single-outstanding write and read FSMs over a word RAM.
// Optional IP_AMBA_AXI_SLAVE_ADDR_CHECK_EN: words beyond MEM_DEPTH answer DECERR instead of aliasing.
module ip_amba_axi_slave_mem #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int LANE_LG = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] inc, wrap_mask;
        inc       = addr + (ADDR_W'(1) << size);
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_INCR: return inc;
            BURST_WRAP: return (addr & ~wrap_mask) | (inc & wrap_mask);
            default:    return addr;
        endcase
    endfunction

    // Burst shapes this slave refuses; every beat of such a burst is an SLVERR beat.
    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'(LANE_LG)) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    // NOTE: the RAM has no reset so it maps onto block RAM; its contents survive ARESET.
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    w_state_t          w_state, w_next;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst, w_resp, w_beat_resp;
    logic              w_bad, w_dec, aw_hs, w_beat, w_len_last, w_we;
    logic [IDX_W-1:0]  w_idx;

    r_state_t          r_state, r_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr, r_ld_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst, r_resp, r_ld_resp;
    logic              r_bad, r_ld_bad, r_dec, r_last, ar_hs, r_hs, r_load;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_ld_idx;

`ifdef IP_AMBA_AXI_SLAVE_ADDR_CHECK_EN
    assign w_dec = |(w_addr >> (LANE_LG + IDX_W));
    assign r_dec = |(r_ld_addr >> (LANE_LG + IDX_W));
`else
    assign w_dec = 1'b0;
    assign r_dec = 1'b0;
`endif

    assign w_idx       = w_addr[LANE_LG +: IDX_W];
    assign w_len_last  = (w_cnt == w_len);
    assign w_beat_resp = w_dec ? RESP_DECERR :
                         (w_bad || (WLAST != w_len_last)) ? RESP_SLVERR : RESP_OKAY;
    assign w_we        = w_beat && (w_beat_resp == RESP_OKAY);

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        w_next  = w_state;
        aw_hs   = 1'b0;
        w_beat  = 1'b0;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BID     = '0;
        BRESP   = RESP_OKAY;
        if (!ARESET) begin
            case (w_state)
                W_IDLE: begin
                    AWREADY = 1'b1;
                    if (AWVALID) begin
                        aw_hs  = 1'b1;
                        w_next = W_DATA;
                    end
                end
                W_DATA: begin
                    WREADY = 1'b1;
                    if (WVALID) begin
                        w_beat = 1'b1;
                        if (WLAST || w_len_last) w_next = W_RESP;
                    end
                end
                W_RESP: begin
                    BVALID = 1'b1;
                    BID    = w_id;
                    BRESP  = w_resp;
                    if (BREADY) w_next = W_IDLE;
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update on the same edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
            w_size <= '0; w_burst <= '0; w_resp <= RESP_OKAY; w_bad <= 1'b0;
        end else if (aw_hs) begin
            w_id <= AWID; w_addr <= AWADDR; w_len <= AWLEN; w_cnt <= '0;
            w_size <= AWSIZE; w_burst <= AWBURST; w_resp <= RESP_OKAY;
            w_bad <= burst_bad(AWLEN, AWSIZE, AWBURST);
        end else if (w_beat) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            // Response codes are ordered so the larger one is the higher-priority error.
            if (w_beat_resp > w_resp) w_resp <= w_beat_resp;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (WSTRB[i]) mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end

    assign r_load    = ar_hs || (r_hs && !r_last);
    assign r_ld_addr = ar_hs ? ARADDR : r_addr;
    assign r_ld_bad  = ar_hs ? burst_bad(ARLEN, ARSIZE, ARBURST) : r_bad;
    assign r_ld_idx  = r_ld_addr[LANE_LG +: IDX_W];
    assign r_ld_resp = r_dec ? RESP_DECERR : (r_ld_bad ? RESP_SLVERR : RESP_OKAY);

    always_comb begin
        r_next  = r_state;
        ar_hs   = 1'b0;
        r_hs    = 1'b0;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RRESP   = RESP_OKAY;
        RLAST   = 1'b0;
        if (!ARESET) begin
            case (r_state)
                R_IDLE: begin
                    ARREADY = 1'b1;
                    if (ARVALID) begin
                        ar_hs  = 1'b1;
                        r_next = R_DATA;
                    end
                end
                R_DATA: begin
                    RVALID = 1'b1;
                    RID    = r_id;
                    RDATA  = r_data;
                    RRESP  = r_resp;
                    RLAST  = r_last;
                    if (RREADY) begin
                        r_hs = 1'b1;
                        if (r_last) r_next = R_IDLE;
                    end
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // r_addr always holds the address of the beat to be loaded after the current one.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0;
            r_burst <= '0; r_bad <= 1'b0; r_last <= 1'b0; r_resp <= RESP_OKAY; r_data <= '0;
        end else begin
            if (ar_hs) begin
                r_id <= ARID; r_len <= ARLEN; r_size <= ARSIZE; r_burst <= ARBURST;
                r_bad  <= r_ld_bad;
                r_addr <= next_addr(ARADDR, ARLEN, ARSIZE, ARBURST);
                r_cnt  <= '0;
                r_last <= (ARLEN == 8'd0);
            end else if (r_hs && !r_last) begin
                r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                r_cnt  <= r_cnt + 8'd1;
                r_last <= ((r_cnt + 8'd1) == r_len);
            end
            if (r_load) begin
                r_resp <= r_ld_resp;
                r_data <= (r_ld_resp == RESP_OKAY) ? mem[r_ld_idx] : '0;
            end
        end
    end
endmodule

// File: tb/tb_ip_amba_axi_slave_mem.sv
// Self-checking bench for ip_amba_axi_slave_mem: directed scenarios plus randomized bursts
// checked against a word-array reference model built from the burst addressing rules.
`timescale 1ns/1ps
module tb_ip_amba_axi_slave_mem;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int MEM_DEPTH = 256;
    localparam int TIMEOUT   = 200;

    logic              ACLK, ARESET;
    logic [ID_W-1:0]   AWID, BID, ARID, RID;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [7:0]        AWLEN, ARLEN;
    logic [2:0]        AWSIZE, ARSIZE;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [3:0]        WSTRB;

    int total, bad;
    logic [31:0] model_mem [MEM_DEPTH];
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];

    ip_amba_axi_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Address of beat i, straight from the FIXED / INCR / WRAP definitions.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        longint s, bytes, wrap, lower;
        s     = longint'(start);
        bytes = longint'(1) << size;
        case (burst)
            1: return 32'(s + i * bytes);
            2: begin
                wrap  = (len + 1) * bytes;
                lower = (s / wrap) * wrap;
                return 32'(lower + (s - lower + i * bytes) % wrap);
            end
            default: return start;
        endcase
    endfunction

    function automatic bit cfg_err(input int len, input int size, input int burst);
        return (size > 2) || (burst == 3) ||
               ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a, input bit err);
        bit dec;
        dec = (a >= 32'(MEM_DEPTH * 4));
`ifndef IP_AMBA_AXI_SLAVE_ADDR_CHECK_EN
        dec = 1'b0;
`endif
        if (dec) return 2'b11;
        if (err) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % MEM_DEPTH);
    endfunction

    // Sends min(wlast_at, len)+1 beats from wbuf/sbuf, WLAST on beat wlast_at; checks B.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input int size, input int burst, input int wlast_at, input string name);
        int nsend, n;
        bit err;
        logic [1:0] exp_resp, r;
        logic [31:0] a;
        err      = cfg_err(len, size, burst);
        nsend    = ((wlast_at < len) ? wlast_at : len) + 1;
        exp_resp = 2'b00;
        for (int i = 0; i < nsend; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            r = resp_of(a, err || ((i == wlast_at) != (i == len)));
            if (r > exp_resp) exp_resp = r;
            if (r == 2'b00)
                for (int b = 0; b < 4; b++)
                    if (sbuf[i][b]) model_mem[midx(a)][8*b +: 8] = wbuf[i][8*b +: 8];
        end
        @(negedge ACLK);
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
        AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < TIMEOUT) begin @(negedge ACLK); n++; end
        if (n >= TIMEOUT) begin
            total++; bad++; AWVALID = 1'b0;
            $display("FAIL %s awready timeout", name);
            return;
        end
        @(posedge ACLK); #1 AWVALID = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            @(negedge ACLK);
            WDATA = wbuf[i]; WSTRB = sbuf[i]; WLAST = (i == wlast_at); WVALID = 1'b1;
            n = 0;
            while (WREADY !== 1'b1 && n < TIMEOUT) begin @(negedge ACLK); n++; end
            if (n >= TIMEOUT) begin
                total++; bad++; WVALID = 1'b0; WLAST = 1'b0;
                $display("FAIL %s wready timeout beat %0d", name, i);
                return;
            end
            @(posedge ACLK); #1 WVALID = 1'b0; WLAST = 1'b0;
        end
        @(negedge ACLK);
        BREADY = 1'b1;
        n = 0;
        while (BVALID !== 1'b1 && n < TIMEOUT) begin @(negedge ACLK); n++; end
        if (n >= TIMEOUT) begin
            total++; bad++; BREADY = 1'b0;
            $display("FAIL %s bvalid timeout", name);
            return;
        end
        total++;
        if (BRESP !== exp_resp) begin bad++; $display("FAIL %s bresp got=%b exp=%b", name, BRESP, exp_resp); end
        total++;
        if (BID !== id) begin bad++; $display("FAIL %s bid got=%h exp=%h", name, BID, id); end
        @(posedge ACLK); #1 BREADY = 1'b0;
    endtask

    // mode 0: RREADY always high, 1: toggles every other cycle, 2: random.
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input int size, input int burst, input int mode, input string name);
        int n, got, cyc, limit;
        bit err, held, rr;
        logic [38:0] held_v;
        logic [31:0] a, exp_d;
        logic [1:0]  exp_r;
        err = cfg_err(len, size, burst);
        @(negedge ACLK);
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
        ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < TIMEOUT) begin @(negedge ACLK); n++; end
        if (n >= TIMEOUT) begin
            total++; bad++; ARVALID = 1'b0;
            $display("FAIL %s arready timeout", name);
            return;
        end
        @(posedge ACLK); #1 ARVALID = 1'b0;
        @(negedge ACLK);
        total++;
        if (RVALID !== 1'b1) begin bad++; $display("FAIL %s rvalid latency got=%b exp=1", name, RVALID); end
        got = 0; held = 1'b0; cyc = 0; limit = 8 * (len + 1) + 50;
        while (got <= len && cyc < limit) begin
            if (held) begin
                total++;
                if (RVALID !== 1'b1 || {RDATA, RRESP, RLAST, RID} !== held_v) begin
                    bad++;
                    $display("FAIL %s stall beat %0d got=%h exp=%h", name, got, {RDATA, RRESP, RLAST, RID}, held_v);
                end
            end
            case (mode)
                0:       rr = 1'b1;
                1:       rr = ((cyc % 2) == 1);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            RREADY = rr;
            held   = 1'b0;
            if (RVALID === 1'b1) begin
                if (rr) begin
                    a     = beat_addr(addr, len, size, burst, got);
                    exp_r = resp_of(a, err);
                    exp_d = (exp_r == 2'b00) ? model_mem[midx(a)] : 32'h0;
                    total++;
                    if (RDATA !== exp_d) begin bad++; $display("FAIL %s rdata beat %0d got=%h exp=%h", name, got, RDATA, exp_d); end
                    total++;
                    if (RRESP !== exp_r) begin bad++; $display("FAIL %s rresp beat %0d got=%b exp=%b", name, got, RRESP, exp_r); end
                    total++;
                    if (RLAST !== (got == len)) begin bad++; $display("FAIL %s rlast beat %0d got=%b exp=%b", name, got, RLAST, got == len); end
                    total++;
                    if (RID !== id) begin bad++; $display("FAIL %s rid beat %0d got=%h exp=%h", name, got, RID, id); end
                    got++;
                end else begin
                    held   = 1'b1;
                    held_v = {RDATA, RRESP, RLAST, RID};
                end
            end
            @(negedge ACLK);
            cyc++;
        end
        RREADY = 1'b0;
        total++;
        if (got <= len) begin
            bad++; $display("FAIL %s beat count got=%0d exp=%0d", name, got, len + 1);
        end else if (RVALID !== 1'b0) begin
            bad++; $display("FAIL %s extra beat rvalid got=%b exp=0", name, RVALID);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        total++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=00000", {AWREADY, WREADY, BVALID, ARREADY, RVALID});
        end
        ARESET = 1'b0;
        #1;
        total++;
        if ({AWREADY, ARREADY} !== 2'b11) begin
            bad++; $display("FAIL reset_release ready got=%b exp=11", {AWREADY, ARREADY});
        end
    endtask

    task automatic test_long_burst();
        for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        write_burst(4'h1, 32'h0, 255, 2, 1, 255, "long_wr");
        read_burst(4'h2, 32'h0, 255, 2, 1, 2, "long_rd");
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        write_burst(4'h3, 32'h10, 0, 2, 1, 0, "single_wr");
        read_burst(4'h9, 32'h10, 0, 2, 1, 0, "single_rd");
    endtask

    task automatic test_incr_backpressure();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        write_burst(4'h4, 32'h20, 3, 2, 1, 3, "incr_wr");
        read_burst(4'h5, 32'h20, 3, 2, 1, 1, "incr_rd_stall");
    endtask

    task automatic test_wrap();
        wbuf[0] = 32'hAAAA_000A; wbuf[1] = 32'hBBBB_000B; wbuf[2] = 32'hCCCC_000C; wbuf[3] = 32'hDDDD_000D;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        write_burst(4'h6, 32'h0, 3, 2, 1, 3, "wrap_fill");
        read_burst(4'h7, 32'h8, 3, 2, 2, 0, "wrap_rd");
        read_burst(4'h8, 32'h8, 2, 2, 2, 0, "wrap_len2_rd");
    endtask

    task automatic test_strobes();
        wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
        write_burst(4'hA, 32'h40, 0, 2, 1, 0, "strb_full");
        wbuf[0] = 32'h0; sbuf[0] = 4'h5;
        write_burst(4'hA, 32'h40, 0, 2, 1, 0, "strb_partial");
        read_burst(4'hB, 32'h40, 0, 2, 1, 0, "strb_rd");
    endtask

    task automatic test_errors();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h5500_0000 + 32'(i); sbuf[i] = 4'hF; end
        write_burst(4'hC, 32'h50, 3, 2, 1, 1, "early_wlast");
        write_burst(4'hC, 32'h60, 1, 2, 1, 1000, "missing_wlast");
        write_burst(4'hD, 32'h70, 0, 3, 1, 0, "size_err_wr");
        write_burst(4'hD, 32'h74, 1, 2, 3, 1, "rsvd_burst_wr");
        write_burst(4'hD, 32'h78, 2, 2, 2, 2, "wrap_len2_wr");
        read_burst(4'hE, 32'h70, 1, 3, 1, 0, "size_err_rd");
        read_burst(4'hE, 32'h74, 1, 2, 3, 0, "rsvd_burst_rd");
        read_burst(4'hE, 32'h50, 3, 2, 1, 0, "err_region_rd");
    endtask

    task automatic test_reset_mid_burst();
        int n;
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE_0000 + 32'(i); sbuf[i] = 4'hF; end
        write_burst(4'h2, 32'h80, 3, 2, 1, 3, "rst_fill");
        @(negedge ACLK);
        ARID = 4'h3; ARADDR = 32'h80; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < TIMEOUT) begin @(negedge ACLK); n++; end
        @(posedge ACLK); #1 ARVALID = 1'b0;
        @(negedge ACLK);
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        total++;
        if (RVALID !== 1'b0) begin bad++; $display("FAIL rst_mid rvalid got=%b exp=0", RVALID); end
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        total++;
        if ({ARREADY, AWREADY, RVALID} !== 3'b110) begin
            bad++; $display("FAIL rst_mid release got=%b exp=110", {ARREADY, AWREADY, RVALID});
        end
        read_burst(4'h4, 32'h80, 3, 2, 1, 0, "rst_intact_rd");
    endtask

    task automatic test_decode();
        logic [1:0] exp_b;
`ifdef IP_AMBA_AXI_SLAVE_ADDR_CHECK_EN
        exp_b = 2'b11;
`else
        exp_b = 2'b00;
`endif
        wbuf[0] = 32'h1234_5678; sbuf[0] = 4'hF;
        write_burst(4'h5, 32'h400, 0, 2, 1, 0, "decode_wr");
        total++;
        if (BRESP !== exp_b) begin bad++; $display("FAIL decode_bresp got=%b exp=%b", BRESP, exp_b); end
        read_burst(4'h6, 32'h0, 0, 2, 1, 0, "decode_rd0");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        fork
            write_burst(4'h7, 32'h200, 7, 2, 1, 7, "b2b_wr");
            read_burst(4'h8, 32'h100, 7, 2, 1, 2, "b2b_rd");
        join
        read_burst(4'h9, 32'h200, 7, 2, 1, 0, "b2b_rd_after");
    endtask

    task automatic test_random();
        int wl [4];
        int burst, size, len, mode;
        logic [31:0] addr;
        wl[0] = 1; wl[1] = 3; wl[2] = 7; wl[3] = 15;
        for (int it = 0; it < 24; it++) begin
            burst = $urandom_range(0, 2);
            size  = $urandom_range(0, 2);
            if (burst == 2)      len = wl[$urandom_range(0, 3)];
            else if (burst == 1) len = $urandom_range(0, 15);
            else                 len = $urandom_range(0, 7);
            addr = 32'($urandom_range(0, 'h3FF));
            mode = $urandom_range(0, 2);
            for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
            write_burst(4'($urandom), addr, len, size, burst, len, "rand_wr");
            read_burst(4'($urandom), addr, len, size, burst, mode, "rand_rd");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = 32'h0;
        test_reset();
        test_long_burst();
        test_single();
        test_incr_backpressure();
        test_wrap();
        test_strobes();
        test_errors();
        test_reset_mid_burst();
        test_decode();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
